// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state
// encodings and the default operand width.
package serial_add_pkg;

  // Default operand width in bits (legal range 2..32).
  localparam int unsigned DEFAULT_WIDTH = 8;

  // Controller states. The encodings are fixed so that other blocks
  // observing the state agree on their meaning.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage : serial_add_pkg

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle of the bit-serial adder. The master side issues
// start with operands; the slave side (the adder) returns busy/done and
// the registered result.
interface serial_add_ctrl_if
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface : serial_add_ctrl_if

// File: rtl/full_adder_st.sv
// Single-bit full-adder cell: one sum bit and one carry-out per call.
module full_adder_st (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  logic half_s;

  assign half_s = a_i ^ b_i;
  assign s_o    = half_s ^ c_i;
  assign c_o    = (a_i & b_i) | (c_i & half_s);

endmodule : full_adder_st

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller. Computes a + b + cin one bit per clock,
// LSB first, through a single full-adder cell. The result and carry-out
// are loaded into output registers only when the last bit is produced,
// so the previous result stays visible for the whole addition.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_add_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e             state_q,  state_d;
  logic [WIDTH-1:0]   a_sr_q,   a_sr_d;
  logic [WIDTH-1:0]   b_sr_q,   b_sr_d;
  logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;
  logic               carry_q,  carry_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [WIDTH-1:0]   sum_q,    sum_d;
  logic               cout_q,   cout_d;

  logic               fa_sum_s;
  logic               fa_carry_s;

  // The one adder cell sees the current LSBs and the running carry.
  full_adder_st u_fa (
    .a_i (a_sr_q[0]),
    .b_i (b_sr_q[0]),
    .c_i (carry_q),
    .s_o (fa_sum_s),
    .c_o (fa_carry_s)
  );

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= {WIDTH{1'b0}};
      b_sr_q   <= {WIDTH{1'b0}};
      sum_sr_q <= {WIDTH{1'b0}};
      carry_q  <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
      sum_q    <= {WIDTH{1'b0}};
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  // Next-state and datapath update: accept in IDLE, one bit per SHIFT
  // cycle, publish result on the final SHIFT cycle, DONE lasts one cycle.
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SHIFT;
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        sum_sr_d = {fa_sum_s, sum_sr_q[WIDTH-1:1]};
        a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
        carry_d  = fa_carry_s;
        if (cnt_q == LAST_CNT) begin
          // Counter parks at its last value instead of wrapping.
          state_d = DONE;
          sum_d   = {fa_sum_s, sum_sr_q[WIDTH-1:1]};
          cout_d  = fa_carry_s;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status is a pure decode of the state register; result comes from flops.
  assign bus.busy = (state_q == SHIFT);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=16.
// Expected results come from plain integer addition; timing expectations
// come from the documented latency and spacing rules.
module tb_serial_add_ctrl;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_errors;
  bit mon_en;

  logic [7:0]  prev_sum8;
  logic        prev_cout8;

  serial_add_ctrl_if #(.WIDTH(8))  bus8  ();
  serial_add_ctrl_if #(.WIDTH(16)) bus16 ();

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  serial_add_ctrl #(.WIDTH(16)) u_dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, want, $time);
    end
  endtask

  // busy and done must never be seen together on either instance.
  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("busy_done_excl8",  64'(bus8.busy & bus8.done), 64'd0);
      check_eq("busy_done_excl16", 64'(bus16.busy & bus16.done), 64'd0);
    end
  end

  // One WIDTH=8 addition. inj: SHIFT cycle (1-based) in which a stray start
  // with a=b=0xFF is pulsed, 0 for none. rcyc: SHIFT cycle in which reset is
  // asserted, 0 for none.
  task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                      input int inj, input int rcyc);
    logic [8:0] ref_v;
    int         busy_n;
    bit         seen;
    ref_v = {1'b0, a} + {1'b0, b} + {8'd0, ci};
    bus8.start = 1'b1;
    bus8.a     = a;
    bus8.b     = b;
    bus8.cin   = ci;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    bus8.a     = 8'($urandom);
    bus8.b     = 8'($urandom);
    bus8.cin   = 1'($urandom);
    busy_n = 0;
    seen   = 1'b0;
    for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
      if (bus8.busy) begin
        busy_n++;
        check_eq("hold_sum8",  64'(bus8.sum),  64'(prev_sum8));
        check_eq("hold_cout8", 64'(bus8.cout), 64'(prev_cout8));
      end
      if (cyc == inj) begin
        bus8.start = 1'b1;
        bus8.a     = 8'hFF;
        bus8.b     = 8'hFF;
        bus8.cin   = 1'b0;
      end else begin
        bus8.start = 1'b0;
      end
      if (cyc == rcyc) rst_n = 1'b0;
      @(posedge clk); #1;
      if (rcyc > 0 && cyc == rcyc) begin
        check_eq("rst_busy", 64'(bus8.busy), 64'd0);
        check_eq("rst_done", 64'(bus8.done), 64'd0);
        check_eq("rst_sum",  64'(bus8.sum),  64'd0);
        check_eq("rst_cout", 64'(bus8.cout), 64'd0);
        rst_n      = 1'b1;
        bus8.start = 1'b0;
        prev_sum8  = 8'h00;
        prev_cout8 = 1'b0;
        for (int i = 0; i < 10; i++) begin
          @(posedge clk); #1;
          check_eq("no_done_after_rst", 64'(bus8.done), 64'd0);
        end
        return;
      end
      if (bus8.done) begin
        seen = 1'b1;
        check_eq("latency8", 64'(cyc), 64'd8);
      end
    end
    bus8.start = 1'b0;
    check_eq("done_seen8", 64'(seen), 64'd1);
    check_eq("busy_cycles8", 64'(busy_n), 64'd8);
    check_eq("sum8",  64'(bus8.sum),  64'(ref_v[7:0]));
    check_eq("cout8", 64'(bus8.cout), 64'(ref_v[8]));
    prev_sum8  = ref_v[7:0];
    prev_cout8 = ref_v[8];
    @(posedge clk); #1;
    check_eq("done_pulse8", 64'(bus8.done), 64'd0);
    if (inj > 0) begin
      for (int i = 0; i < 12; i++) begin
        check_eq("single_done8", 64'(bus8.done | bus8.busy), 64'd0);
        @(posedge clk); #1;
      end
      check_eq("sum_after_inj8", 64'(bus8.sum), 64'(ref_v[7:0]));
    end
  endtask

  // One WIDTH=16 addition with latency and result checks.
  task automatic add16(input logic [15:0] a, input logic [15:0] b, input logic ci);
    logic [16:0] ref_v;
    bit          seen;
    ref_v = {1'b0, a} + {1'b0, b} + {16'd0, ci};
    bus16.start = 1'b1;
    bus16.a     = a;
    bus16.b     = b;
    bus16.cin   = ci;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    bus16.a     = 16'($urandom);
    bus16.b     = 16'($urandom);
    seen = 1'b0;
    for (int cyc = 1; cyc <= 60 && !seen; cyc++) begin
      @(posedge clk); #1;
      if (bus16.done) begin
        seen = 1'b1;
        check_eq("latency16", 64'(cyc), 64'd16);
      end
    end
    check_eq("done_seen16", 64'(seen), 64'd1);
    check_eq("sum16", 64'({bus16.cout, bus16.sum}), 64'(ref_v));
    @(posedge clk); #1;
  endtask

  initial begin
    clk         = 1'b0;
    rst_n       = 1'b0;
    n_checks    = 0;
    n_errors    = 0;
    mon_en      = 1'b0;
    prev_sum8   = 8'h00;
    prev_cout8  = 1'b0;
    bus8.start  = 1'b1;
    bus8.a      = 8'h11;
    bus8.b      = 8'h22;
    bus8.cin    = 1'b0;
    bus16.start = 1'b0;
    bus16.a     = 16'h0;
    bus16.b     = 16'h0;
    bus16.cin   = 1'b0;

    // Reset with start held high: start must be ignored.
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    check_eq("reset_busy8", 64'(bus8.busy), 64'd0);
    check_eq("reset_done8", 64'(bus8.done), 64'd0);
    check_eq("reset_sum8",  64'(bus8.sum),  64'd0);
    check_eq("reset_cout8", 64'(bus8.cout), 64'd0);
    check_eq("reset_res16", 64'({bus16.busy, bus16.done, bus16.cout, bus16.sum}), 64'd0);
    rst_n      = 1'b1;
    bus8.start = 1'b0;
    @(posedge clk); #1;
    check_eq("start_in_reset_ignored", 64'(bus8.busy), 64'd0);

    // Directed cases.
    add8(8'hFF, 8'h01, 1'b0, 0, 0);
    add8(8'h5A, 8'hA5, 1'b1, 0, 0);
    add8(8'h5A, 8'hA5, 1'b0, 0, 0);
    add8(8'h12, 8'h34, 1'b0, 0, 0);
    check_eq("first_result_46", 64'(bus8.sum), 64'h46);
    add8(8'h10, 8'h20, 1'b0, 3, 0);
    add8(8'h12, 8'h34, 1'b0, 0, 0);
    add8(8'h77, 8'h99, 1'b1, 0, 4);
    add8(8'h00, 8'h00, 1'b0, 0, 0);
    add8(8'h80, 8'h80, 1'b1, 0, 0);

    // Random regression at both widths.
    for (int i = 0; i < 1000; i++) begin
      add8(8'($urandom), 8'($urandom), 1'($urandom), 0, 0);
    end
    for (int i = 0; i < 1000; i++) begin
      add16(16'($urandom), 16'($urandom), 1'($urandom));
    end

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_serial_add_ctrl
